// File: rtl/sc_regresult_pkg.sv
// sc_regresult_pkg: shared types and defaults for the result-capture block.
//   state_e            - FSM state encoding (IDLE/RUN/DONE)
//   DATAWIDTH_BUS_DEF  - default captured word width
//   STEPWIDTH_DEF      - default step counter width
package sc_regresult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int DATAWIDTH_BUS_DEF = 8;
    localparam int STEPWIDTH_DEF     = 8;

endpackage

// File: rtl/sc_regresult_if.sv
// sc_regresult_if: bundle of the capture-run stimulus and status signals.
//   master: drives start/valid/data, observes the result outputs
//   slave : the capture block side
// Build option: SC_REGRESULT_PEAK_EN only affects the value carried on peak.
interface sc_regresult_if #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int STEPWIDTH     = 8
);
    logic                     start;
    logic                     valid;
    logic [DATAWIDTH_BUS-1:0] data;
    logic [DATAWIDTH_BUS-1:0] data_out;
    logic [STEPWIDTH-1:0]     steps;
    logic [DATAWIDTH_BUS-1:0] peak;
    logic                     busy;
    logic                     done;
    logic                     ovf;
    logic                     err;

    modport master (
        output start, valid, data,
        input  data_out, steps, peak, busy, done, ovf, err
    );

    modport slave (
        input  start, valid, data,
        output data_out, steps, peak, busy, done, ovf, err
    );
endinterface

// File: rtl/sc_satcounter.sv
// sc_satcounter: saturating up-counter with sticky overflow flag.
//   clk_i  - clock, rising edge
//   rst_ni - synchronous active-low reset (count and flag to 0)
//   clr_i  - synchronous clear (count and flag to 0), beats en_i
//   en_i   - increment request
//   cnt_o  - current count, saturates at all-ones
//   ovf_o  - set when an increment is requested at saturation; sticky
module sc_satcounter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            if (at_max) ovf_d = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/sc_regresult.sv
// sc_regresult: captures a run of datapath result words (e.g. sequence terms)
// after a start pulse, counting words and tracking the peak, until a word of
// 1 (normal end) or 0 (error end) arrives.
//   SC_RegRESULT_CLOCK_50      - clock, rising edge
//   SC_RegRESULT_RESET_InLow   - synchronous active-low reset
//   SC_RegRESULT_start_In      - arms a new run (beats valid the same cycle)
//   SC_RegRESULT_valid_In      - word present on data_InBUS
//   SC_RegRESULT_data_InBUS    - datapath word
//   SC_RegRESULT_data_OutBUS   - last captured word
//   SC_RegRESULT_steps_OutBUS  - accepted words this run (saturating)
//   SC_RegRESULT_peak_OutBUS   - largest word this run
//   SC_RegRESULT_busy/done/ovf/err_Out - status flags
// Build option: define SC_REGRESULT_PEAK_EN to enable peak tracking;
// otherwise peak_OutBUS is tied to 0 and no peak logic exists.
module sc_regresult
    import sc_regresult_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
    parameter int STEPWIDTH     = STEPWIDTH_DEF
) (
    input  logic                     SC_RegRESULT_CLOCK_50,
    input  logic                     SC_RegRESULT_RESET_InLow,
    input  logic                     SC_RegRESULT_start_In,
    input  logic                     SC_RegRESULT_valid_In,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegRESULT_data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_RegRESULT_data_OutBUS,
    output logic [STEPWIDTH-1:0]     SC_RegRESULT_steps_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] SC_RegRESULT_peak_OutBUS,
    output logic                     SC_RegRESULT_busy_Out,
    output logic                     SC_RegRESULT_done_Out,
    output logic                     SC_RegRESULT_ovf_Out,
    output logic                     SC_RegRESULT_err_Out
);
    state_e                   state_q;
    logic [DATAWIDTH_BUS-1:0] data_q;
    logic                     busy_q, done_q, err_q;
    logic                     accept;
    logic                     is_one, is_zero;

    // A word is taken only while running and only if no start arrives with it.
    assign accept  = (state_q == ST_RUN) && SC_RegRESULT_valid_In && !SC_RegRESULT_start_In;
    assign is_one  = (SC_RegRESULT_data_InBUS == DATAWIDTH_BUS'(1));
    assign is_zero = (SC_RegRESULT_data_InBUS == '0);

    sc_satcounter #(.WIDTH(STEPWIDTH)) u_steps (
        .clk_i  (SC_RegRESULT_CLOCK_50),
        .rst_ni (SC_RegRESULT_RESET_InLow),
        .clr_i  (SC_RegRESULT_start_In),
        .en_i   (accept),
        .cnt_o  (SC_RegRESULT_steps_OutBUS),
        .ovf_o  (SC_RegRESULT_ovf_Out)
    );

    always_ff @(posedge SC_RegRESULT_CLOCK_50) begin
        if (!SC_RegRESULT_RESET_InLow) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (SC_RegRESULT_start_In) begin
            // captured word is deliberately kept across a restart
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (SC_RegRESULT_valid_In) begin
                        data_q <= SC_RegRESULT_data_InBUS;
                        if (is_one || is_zero) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= is_zero;
                        end
                    end
                end
                default: ; // IDLE and DONE hold everything
            endcase
        end
    end

`ifdef SC_REGRESULT_PEAK_EN
    logic [DATAWIDTH_BUS-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (accept && (SC_RegRESULT_data_InBUS > peak_q)) peak_d = SC_RegRESULT_data_InBUS;
    end

    always_ff @(posedge SC_RegRESULT_CLOCK_50) begin
        if (!SC_RegRESULT_RESET_InLow || SC_RegRESULT_start_In) peak_q <= '0;
        else                                                    peak_q <= peak_d;
    end

    assign SC_RegRESULT_peak_OutBUS = peak_q;
`else
    assign SC_RegRESULT_peak_OutBUS = '0;
`endif

    assign SC_RegRESULT_data_OutBUS = data_q;
    assign SC_RegRESULT_busy_Out    = busy_q;
    assign SC_RegRESULT_done_Out    = done_q;
    assign SC_RegRESULT_err_Out     = err_q;
endmodule

// File: tb/tb_sc_regresult.sv
// tb_sc_regresult: drives two instances (STEPWIDTH 8 and 2) with identical
// stimulus and compares every output after every edge with a run-level model,
// plus constant expectations at the end of each directed scenario.
module tb_sc_regresult;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

`ifdef SC_REGRESULT_PEAK_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    sc_regresult_if #(.DATAWIDTH_BUS(8), .STEPWIDTH(8)) a_if ();
    sc_regresult_if #(.DATAWIDTH_BUS(8), .STEPWIDTH(2)) b_if ();

    sc_regresult #(.DATAWIDTH_BUS(8), .STEPWIDTH(8)) dut_a (
        .SC_RegRESULT_CLOCK_50     (clk),
        .SC_RegRESULT_RESET_InLow  (rst_n),
        .SC_RegRESULT_start_In     (a_if.start),
        .SC_RegRESULT_valid_In     (a_if.valid),
        .SC_RegRESULT_data_InBUS   (a_if.data),
        .SC_RegRESULT_data_OutBUS  (a_if.data_out),
        .SC_RegRESULT_steps_OutBUS (a_if.steps),
        .SC_RegRESULT_peak_OutBUS  (a_if.peak),
        .SC_RegRESULT_busy_Out     (a_if.busy),
        .SC_RegRESULT_done_Out     (a_if.done),
        .SC_RegRESULT_ovf_Out      (a_if.ovf),
        .SC_RegRESULT_err_Out      (a_if.err)
    );

    sc_regresult #(.DATAWIDTH_BUS(8), .STEPWIDTH(2)) dut_b (
        .SC_RegRESULT_CLOCK_50     (clk),
        .SC_RegRESULT_RESET_InLow  (rst_n),
        .SC_RegRESULT_start_In     (b_if.start),
        .SC_RegRESULT_valid_In     (b_if.valid),
        .SC_RegRESULT_data_InBUS   (b_if.data),
        .SC_RegRESULT_data_OutBUS  (b_if.data_out),
        .SC_RegRESULT_steps_OutBUS (b_if.steps),
        .SC_RegRESULT_peak_OutBUS  (b_if.peak),
        .SC_RegRESULT_busy_Out     (b_if.busy),
        .SC_RegRESULT_done_Out     (b_if.done),
        .SC_RegRESULT_ovf_Out      (b_if.ovf),
        .SC_RegRESULT_err_Out      (b_if.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-level model: "running"/"finished" describe where the run is, not an encoding.
    typedef struct {
        int  maxsteps;
        bit  running;
        int  data;
        int  steps;
        int  peak;
        bit  busy, done, ovf, err;
    } model_t;

    model_t ma, mb;

    function automatic model_t mstep(model_t m, bit rst, bit start, bit valid, int d);
        model_t n = m;
        if (!rst) begin
            n.running = 0; n.data = 0; n.steps = 0; n.peak = 0;
            n.busy = 0; n.done = 0; n.ovf = 0; n.err = 0;
        end else if (start) begin
            n.running = 1; n.steps = 0; n.peak = 0;
            n.busy = 1; n.done = 0; n.ovf = 0; n.err = 0;
        end else if (m.running && valid) begin
            n.data = d;
            if (m.steps == m.maxsteps) n.ovf = 1;
            else                       n.steps = m.steps + 1;
            if (PEAK && d > m.peak) n.peak = d;
            if (d <= 1) begin
                n.running = 0; n.busy = 0; n.done = 1; n.err = (d == 0);
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("a.data",  32'(a_if.data_out), 32'(ma.data));
        chk("a.steps", 32'(a_if.steps),    32'(ma.steps));
        chk("a.peak",  32'(a_if.peak),     32'(ma.peak));
        chk("a.busy",  32'(a_if.busy),     32'(ma.busy));
        chk("a.done",  32'(a_if.done),     32'(ma.done));
        chk("a.ovf",   32'(a_if.ovf),      32'(ma.ovf));
        chk("a.err",   32'(a_if.err),      32'(ma.err));
        chk("b.data",  32'(b_if.data_out), 32'(mb.data));
        chk("b.steps", 32'(b_if.steps),    32'(mb.steps));
        chk("b.peak",  32'(b_if.peak),     32'(mb.peak));
        chk("b.busy",  32'(b_if.busy),     32'(mb.busy));
        chk("b.done",  32'(b_if.done),     32'(mb.done));
        chk("b.ovf",   32'(b_if.ovf),      32'(mb.ovf));
        chk("b.err",   32'(b_if.err),      32'(mb.err));
    endtask

    // Apply one cycle of inputs to both instances, then check after the edge.
    task automatic cyc(input bit rst, input bit start, input bit valid, input int d);
        @(negedge clk);
        rst_n = rst;
        a_if.start = start; a_if.valid = valid; a_if.data = 8'(d);
        b_if.start = start; b_if.valid = valid; b_if.data = 8'(d);
        @(posedge clk);
        ma = mstep(ma, rst, start, valid, d);
        mb = mstep(mb, rst, start, valid, d);
        #1;
        chk_model();
    endtask

    int seq [8] = '{3, 10, 5, 16, 8, 4, 2, 1};

    initial begin
        ma = '{maxsteps: 255, default: 0};
        mb = '{maxsteps: 3,   default: 0};
        rst_n = 1'b0;
        a_if.start = 0; a_if.valid = 0; a_if.data = 0;
        b_if.start = 0; b_if.valid = 0; b_if.data = 0;

        // reset state
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 9);            // reset beats start and valid
        chk("rst.data",  32'(a_if.data_out), 0);
        chk("rst.steps", 32'(a_if.steps), 0);
        chk("rst.busy",  32'(a_if.busy), 0);
        chk("rst.done",  32'(a_if.done), 0);

        // IDLE ignores valid
        cyc(1, 0, 1, 7);
        chk("idle.data", 32'(a_if.data_out), 0);
        chk("idle.busy", 32'(a_if.busy), 0);

        // normal run ending on 1
        cyc(1, 1, 0, 0);
        chk("start.busy", 32'(a_if.busy), 1);
        foreach (seq[i]) cyc(1, 0, 1, seq[i]);
        chk("seq.steps", 32'(a_if.steps), 8);
        chk("seq.peak",  32'(a_if.peak), PEAK ? 16 : 0);
        chk("seq.data",  32'(a_if.data_out), 1);
        chk("seq.done",  32'(a_if.done), 1);
        chk("seq.busy",  32'(a_if.busy), 0);
        chk("seq.b.steps", 32'(b_if.steps), 3);
        chk("seq.b.ovf",   32'(b_if.ovf), 1);

        // DONE holds
        cyc(1, 0, 1, 9);
        chk("done.hold.data", 32'(a_if.data_out), 1);

        // start beats valid; captured word survives restart
        cyc(1, 1, 1, 9);
        chk("sv.steps", 32'(a_if.steps), 0);
        chk("sv.data",  32'(a_if.data_out), 1);
        chk("sv.busy",  32'(a_if.busy), 1);

        // error end on 0
        cyc(1, 0, 1, 5);
        cyc(1, 0, 0, 0);            // idle cycle in RUN, nothing changes
        cyc(1, 0, 1, 0);
        chk("err.err",   32'(a_if.err), 1);
        chk("err.done",  32'(a_if.done), 1);
        chk("err.steps", 32'(a_if.steps), 2);
        chk("err.data",  32'(a_if.data_out), 0);

        // saturation on the 2-bit instance
        cyc(1, 1, 0, 0);
        repeat (5) cyc(1, 0, 1, 7);
        chk("sat.steps", 32'(b_if.steps), 3);
        chk("sat.ovf",   32'(b_if.ovf), 1);
        chk("sat.busy",  32'(b_if.busy), 1);
        chk("sat.done",  32'(b_if.done), 0);
        chk("sat.a.steps", 32'(a_if.steps), 5);

        // reset mid-run
        cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 0, 1, 7);
        chk("mid.steps", 32'(a_if.steps), 4);
        cyc(0, 0, 1, 7);
        chk("mid.rst.steps", 32'(a_if.steps), 0);
        chk("mid.rst.data",  32'(a_if.data_out), 0);
        chk("mid.rst.busy",  32'(a_if.busy), 0);
        cyc(1, 0, 1, 7);
        chk("mid.ign.data",  32'(a_if.data_out), 0);
        chk("mid.ign.steps", 32'(a_if.steps), 0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit r, s, v;
            int d;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 255);
            cyc(r, s, v, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sc_regresult.md
SC_REGRESULT -- requirements
Module: sc_regresult

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 8, width of captured datapath words.
REQ-002 SHALL have parameter STEPWIDTH, default 8, width of the step counter.
REQ-003 SHALL have port SC_RegRESULT_CLOCK_50  input  1  single system clock, all state updates on rising edge.
REQ-004 SHALL have port SC_RegRESULT_RESET_InLow  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port SC_RegRESULT_start_In  input  1  one-cycle pulse that arms a new capture run.
REQ-006 SHALL have port SC_RegRESULT_valid_In  input  1  datapath word present on data_InBUS this cycle.
REQ-007 SHALL have port SC_RegRESULT_data_InBUS  input  DATAWIDTH_BUS  datapath result word (sequence term).
REQ-008 SHALL have port SC_RegRESULT_data_OutBUS  output  DATAWIDTH_BUS  last captured word.
REQ-009 SHALL have port SC_RegRESULT_steps_OutBUS  output  STEPWIDTH  accepted words in current run.
REQ-010 SHALL have port SC_RegRESULT_peak_OutBUS  output  DATAWIDTH_BUS  maximum word in current run.
REQ-011 SHALL have ports SC_RegRESULT_busy_Out, _done_Out, _ovf_Out, _err_Out  output  1 each  status flags.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN, DONE; the state is not exported directly.
REQ-013 In IDLE: all outputs hold; valid_In ignored; busy=0.
REQ-014 start_In=1 in any state: next cycle steps=0, peak=0, done=0, ovf=0, err=0, data_OutBUS unchanged, state RUN, busy=1.
REQ-015 start_In SHALL take priority over valid_In in the same cycle; that valid word is discarded.
REQ-016 In RUN with valid_In=1: next cycle data_OutBUS=data_InBUS and steps incremented by 1, giving one-cycle latency.
REQ-017 Step counter SHALL saturate at 2^STEPWIDTH-1; an increment attempted at saturation sets ovf=1, which is sticky until start or reset.
REQ-018 In RUN, peak SHALL be updated to data_InBUS when the word is unsigned greater than the current peak.
REQ-019 An accepted word equal to 1 SHALL move RUN to DONE: done=1, busy=0, and that word is counted and captured.
REQ-020 An accepted word equal to 0 SHALL move RUN to DONE with err=1 and done=1; the word is counted and captured.
REQ-021 In RUN with valid_In=0: no output change.
REQ-022 In DONE: all outputs hold; valid_In ignored; only start or reset leaves DONE.

Reset
REQ-023 On a rising clock edge with RESET_InLow=0: state IDLE, and data_OutBUS, steps, peak, busy, done, ovf, err all 0.
REQ-024 Reset SHALL override start_In and valid_In in the same cycle, including in the middle of a run; no asynchronous path.

Configuration
REQ-025 SC_REGRESULT_PEAK_EN defined: peak tracking per REQ-018.
REQ-026 SC_REGRESULT_PEAK_EN undefined: no comparator or peak register, and peak_OutBUS is constant 0.

Structure
REQ-027 Shared package sc_regresult_pkg SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default width constants.
REQ-028 Step counter SHALL be a sub-module sc_satcounter (clear, enable, saturate, overflow flag).

Verification
REQ-029 Start, then valid words 3,10,5,16,8,4,2,1 on consecutive cycles -> steps=8, peak=16, data_OutBUS=1, done=1, busy=0.
REQ-030 Start with STEPWIDTH=2, then five words of 7 -> steps=3, ovf=1, busy=1, still in RUN.
REQ-031 Start, then word 5, then word 0 -> err=1, done=1, steps=2, data_OutBUS=0.
REQ-032 Start and valid=1 with data 9 in the same cycle -> steps=0, data_OutBUS unchanged, busy=1.
REQ-033 RUN with steps=4, drive RESET_InLow=0 for one edge -> all outputs 0, IDLE; a following valid word 7 is ignored.
REQ-034 Build without SC_REGRESULT_PEAK_EN, repeat the REQ-029 stimulus -> peak_OutBUS=0, all other outputs as in REQ-029.
